// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the sequencing controller:
// stall requests and redirects in, stall vector, flush and perf counters out.
interface pipe_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             redirect_req;
    logic [PC_W-1:0]  redirect_pc;
    logic             cnt_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [PC_W-1:0]  new_pc;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output redirect_req, redirect_pc, cnt_clr,
        input  stall, flush, new_pc, ctrl_state, stall_cycles, flush_count
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  redirect_req, redirect_pc, cnt_clr,
        output stall, flush, new_pc, ctrl_state, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: priority stall vector, deferred redirect
// sequencing into a one-cycle flush, and saturating stall/flush counters.
module pipe_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_target;
    logic [PC_W-1:0]  w_target_nxt;
    logic [PC_W-1:0]  r_new_pc;
    logic [PC_W-1:0]  w_new_pc_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [5:0]       w_stall_req;
    logic [5:0]       w_stall;
    logic             w_blocked;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Deepest stalled stage freezes itself and every stage upstream of it.
    always_comb begin
        w_stall_req = 6'b000000;
        if (bus.stallreq_mem)
            w_stall_req = 6'b011111;
        else if (bus.stallreq_ex)
            w_stall_req = 6'b001111;
        else if (bus.stallreq_id)
            w_stall_req = 6'b000111;
        else if (bus.stallreq_if)
            w_stall_req = 6'b000011;
    end

    assign w_stall   = (!rst || r_state == FLUSH) ? 6'b000000 : w_stall_req;
    assign w_blocked = bus.stallreq_if | bus.stallreq_mem;

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_new_pc_nxt = r_new_pc;
        w_flush_nxt  = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.redirect_req) begin
                    w_target_nxt = bus.redirect_pc;
                    if (w_blocked) begin
                        w_state_nxt = PEND;
                    end else begin
                        w_state_nxt  = FLUSH;
                        w_new_pc_nxt = bus.redirect_pc;
                        w_flush_nxt  = 1'b1;
                    end
                end
            end
            // Younger redirects arriving here are ignored; the captured target stands.
            PEND: begin
                if (!w_blocked) begin
                    w_state_nxt  = FLUSH;
                    w_new_pc_nxt = r_target;
                    w_flush_nxt  = 1'b1;
                end
            end
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_target <= '0;
            r_new_pc <= '0;
            r_flush  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_new_pc <= w_new_pc_nxt;
            r_flush  <= w_flush_nxt;
        end
    end

    // Clear wins over increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall[0])
                r_stall_cycles <= sat_inc(r_stall_cycles);
            if (r_state == FLUSH)
                r_flush_count <= sat_inc(r_flush_count);
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = r_flush;
    assign bus.new_pc       = r_new_pc;
    assign bus.ctrl_state   = r_state;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a 16-bit-counter and a 4-bit-counter instance share
// stimulus and are both compared every cycle against a rule-level model.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.PC_W(32), .CNT_W(16)) bus16 ();
    pipe_ctrl_if #(.PC_W(32), .CNT_W(4))  bus4 ();

    assign bus4.stallreq_if  = bus16.stallreq_if;
    assign bus4.stallreq_id  = bus16.stallreq_id;
    assign bus4.stallreq_ex  = bus16.stallreq_ex;
    assign bus4.stallreq_mem = bus16.stallreq_mem;
    assign bus4.redirect_req = bus16.redirect_req;
    assign bus4.redirect_pc  = bus16.redirect_pc;
    assign bus4.cnt_clr      = bus16.cnt_clr;

    pipe_ctrl #(.PC_W(32), .CNT_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    pipe_ctrl #(.PC_W(32), .CNT_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stall vector: ones from bit0 up to and including the deepest requesting stage.
    function automatic logic [5:0] exp_stall(input logic rv, input bit fl,
                                             input logic rif, input logic rid,
                                             input logic rex, input logic rmem);
        int n;
        n = 0;
        if (rmem)     n = 5;
        else if (rex) n = 4;
        else if (rid) n = 3;
        else if (rif) n = 2;
        if (!rv || fl) n = 0;
        return 6'((1 << n) - 1);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model state: a pending redirect flag, a flushing flag, targets, raw event counts.
    bit          m_pend  = 1'b0;
    bit          m_flush = 1'b0;
    logic [31:0] m_tgt   = '0;
    logic [31:0] m_newpc = '0;
    int          m_sc    = 0;
    int          m_fc    = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend  <= 1'b0;
            m_flush <= 1'b0;
            m_tgt   <= '0;
            m_newpc <= '0;
            m_sc    <= 0;
            m_fc    <= 0;
        end else begin
            if (bus16.cnt_clr) begin
                m_sc <= 0;
                m_fc <= 0;
            end else begin
                if (exp_stall(rst, m_flush, bus16.stallreq_if, bus16.stallreq_id,
                              bus16.stallreq_ex, bus16.stallreq_mem) != 6'd0)
                    m_sc <= m_sc + 1;
                if (m_flush)
                    m_fc <= m_fc + 1;
            end
            if (m_flush) begin
                m_flush <= 1'b0;
            end else if (m_pend) begin
                if (!bus16.stallreq_if && !bus16.stallreq_mem) begin
                    m_pend  <= 1'b0;
                    m_flush <= 1'b1;
                    m_newpc <= m_tgt;
                end
            end else if (bus16.redirect_req) begin
                m_tgt <= bus16.redirect_pc;
                if (bus16.stallreq_if || bus16.stallreq_mem) begin
                    m_pend <= 1'b1;
                end else begin
                    m_flush <= 1'b1;
                    m_newpc <= bus16.redirect_pc;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] es;
        logic [1:0] est;
        es  = exp_stall(rst, m_flush, bus16.stallreq_if, bus16.stallreq_id,
                        bus16.stallreq_ex, bus16.stallreq_mem);
        est = m_flush ? 2'd2 : (m_pend ? 2'd1 : 2'd0);
        chk("stall16", bus16.stall, es);
        chk("stall4", bus4.stall, es);
        chk("flush16", bus16.flush, m_flush);
        chk("flush4", bus4.flush, m_flush);
        chk("state16", bus16.ctrl_state, est);
        chk("state4", bus4.ctrl_state, est);
        chk("stall_cycles16", bus16.stall_cycles, sat(m_sc, 16));
        chk("stall_cycles4", bus4.stall_cycles, sat(m_sc, 4));
        chk("flush_count16", bus16.flush_count, sat(m_fc, 16));
        chk("flush_count4", bus4.flush_count, sat(m_fc, 4));
        if (m_flush) begin
            chk("new_pc16", bus16.new_pc, m_newpc);
            chk("new_pc4", bus4.new_pc, m_newpc);
        end
    end

    // One clock cycle of stimulus; req = {mem, ex, id, if}.
    task automatic cyc(input logic [3:0] req, input logic red, input logic [31:0] pc,
                       input logic clr);
        @(posedge clk);
        #1;
        bus16.stallreq_if  = req[0];
        bus16.stallreq_id  = req[1];
        bus16.stallreq_ex  = req[2];
        bus16.stallreq_mem = req[3];
        bus16.redirect_req = red;
        bus16.redirect_pc  = pc;
        bus16.cnt_clr      = clr;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus16.stallreq_if  = 1'b1;
        bus16.stallreq_id  = 1'b1;
        bus16.stallreq_ex  = 1'b1;
        bus16.stallreq_mem = 1'b1;
        bus16.redirect_req = 1'b1;
        bus16.redirect_pc  = 32'hDEAD_BEEF;
        bus16.cnt_clr      = 1'b0;
        #1 rst = 1'b0;

        // Reset with all requests high
        repeat (3) @(posedge clk);
        #2;
        chk("t1_stall_in_reset", bus16.stall, 6'b000000);
        chk("t1_flush_in_reset", bus16.flush, 1'b0);
        chk("t1_state_in_reset", bus16.ctrl_state, 2'd0);
        chk("t1_cnt_in_reset", bus16.stall_cycles, 16'd0);
        bus16.redirect_req = 1'b0;
        rst = 1'b1;
        cyc(4'b1111, 1'b0, 32'h0, 1'b0);
        chk("t1_stall_after_release", bus16.stall, 6'b011111);

        // Priority
        cyc(4'b1010, 1'b0, 32'h0, 1'b0);
        chk("t2_id_mem", bus16.stall, 6'b011111);
        cyc(4'b0010, 1'b0, 32'h0, 1'b0);
        chk("t2_id_only", bus16.stall, 6'b000111);
        cyc(4'b0001, 1'b0, 32'h0, 1'b0);
        chk("t2_if_only", bus16.stall, 6'b000011);
        cyc(4'b0100, 1'b0, 32'h0, 1'b0);
        chk("t2_ex_only", bus16.stall, 6'b001111);

        // Clean redirect
        cyc(4'b0000, 1'b0, 32'h0, 1'b1);
        cyc(4'b0000, 1'b1, 32'h0000_0100, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t3_flush", bus16.flush, 1'b1);
        chk("t3_new_pc", bus16.new_pc, 32'h0000_0100);
        chk("t3_state_flush", bus16.ctrl_state, 2'd2);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t3_flush_done", bus16.flush, 1'b0);
        chk("t3_state_run", bus16.ctrl_state, 2'd0);
        chk("t3_flush_count", bus16.flush_count, 16'd1);

        // Deferred redirect behind a memory stall
        cyc(4'b0000, 1'b0, 32'h0, 1'b1);
        cyc(4'b1000, 1'b1, 32'h0000_0200, 1'b0);
        cyc(4'b1000, 1'b1, 32'h0000_0300, 1'b0);
        chk("t4_pend1", bus16.ctrl_state, 2'd1);
        cyc(4'b1000, 1'b0, 32'h0, 1'b0);
        chk("t4_pend2", bus16.ctrl_state, 2'd1);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t4_pend3", bus16.ctrl_state, 2'd1);
        chk("t4_no_early_flush", bus16.flush, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t4_flush", bus16.flush, 1'b1);
        chk("t4_new_pc", bus16.new_pc, 32'h0000_0200);
        chk("t4_stall_cycles", bus16.stall_cycles, 16'd3);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);

        // Flush overrides stall; redirect during flush ignored
        cyc(4'b0100, 1'b1, 32'h0000_0400, 1'b0);
        cyc(4'b0100, 1'b1, 32'h0000_0500, 1'b0);
        chk("t5_flush", bus16.flush, 1'b1);
        chk("t5_stall_forced_zero", bus16.stall, 6'b000000);
        cyc(4'b0100, 1'b0, 32'h0, 1'b0);
        chk("t5_stall_after", bus16.stall, 6'b001111);
        chk("t5_no_second_flush", bus16.flush, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t5_still_run", bus16.ctrl_state, 2'd0);

        // Saturation on the narrow counter, clear priority
        cyc(4'b0000, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(4'b0010, 1'b0, 32'h0, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t6_sat4", bus4.stall_cycles, 4'd15);
        chk("t6_wide20", bus16.stall_cycles, 16'd20);
        cyc(4'b0010, 1'b0, 32'h0, 1'b1);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t6_clr4", bus4.stall_cycles, 4'd0);
        chk("t6_clr16", bus16.stall_cycles, 16'd0);

        // Async reset in PEND drops the redirect
        cyc(4'b1000, 1'b1, 32'h0000_0600, 1'b0);
        cyc(4'b1000, 1'b0, 32'h0, 1'b0);
        chk("t7_pend", bus16.ctrl_state, 2'd1);
        rst = 1'b0;
        #1;
        chk("t7_rst_state", bus16.ctrl_state, 2'd0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t7_no_flush_after", bus16.flush, 1'b0);

        // Async reset in FLUSH deasserts flush at once
        cyc(4'b0000, 1'b1, 32'h0000_0700, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("t8_flush", bus16.flush, 1'b1);
        rst = 1'b0;
        #1;
        chk("t8_flush_dropped", bus16.flush, 1'b0);
        chk("t8_new_pc_reset", bus16.new_pc, 32'h0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);
        cyc(4'b0000, 1'b0, 32'h0, 1'b0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
